// File: rtl/baudrate_gen_frac.sv
// Fractional baud-rate generator for the UART datapath.
// The divisor is an I.F value (integer I, fraction F over 2^FRAC_NBITS).
// Tick periods are I or I+1 clocks, so the average period is I + F/2^FRAC_NBITS.
// Divisor writes go to a shadow register and are applied at the next tick
// boundary, so the period already running is never cut short or stretched.
//
// Ports:
//   i_clk, i_rst_n   clock; asynchronous active-low reset
//   i_en             run enable; all counting freezes while low
//   i_sync           phase restart; overrides the tick boundary and i_en
//   i_div_wr, i_div  divisor write strobe and value {I, F}
//   o_tick           1-cycle oversample tick
//   o_bit_tick       1-cycle bit tick, high with every OVERSAMPLE-th o_tick
//   o_div_err        1-cycle pulse when a written I was 0 and clamped to 1
//   o_div_pend       a written divisor is waiting to be applied
module baudrate_gen_frac #(
  parameter real CLK_FREQ   = 100E6,
  parameter real BAUD_RATE  = 9600,
  parameter int  OVERSAMPLE = 16,
  parameter int  INT_NBITS  = 16,
  parameter int  FRAC_NBITS = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_en,
  input  logic                            i_sync,
  input  logic                            i_div_wr,
  input  logic [INT_NBITS+FRAC_NBITS-1:0] i_div,
  output logic                            o_tick,
  output logic                            o_bit_tick,
  output logic                            o_div_err,
  output logic                            o_div_pend
);

  localparam int DIV_NBITS   = INT_NBITS + FRAC_NBITS;
  localparam int SCNT_NBITS  = $clog2(OVERSAMPLE);
  localparam int DIV_RST_VAL = $rtoi(CLK_FREQ * real'(2 ** FRAC_NBITS) /
                                     (real'(OVERSAMPLE) * BAUD_RATE) + 0.5);
  localparam logic [DIV_NBITS-1:0]  DIV_RST  = DIV_NBITS'(DIV_RST_VAL);
  localparam logic [INT_NBITS-1:0]  RST_INT  = DIV_RST[DIV_NBITS-1:FRAC_NBITS];
  localparam logic [FRAC_NBITS-1:0] RST_FRAC = DIV_RST[FRAC_NBITS-1:0];

  logic [INT_NBITS-1:0]  cnt;
  logic [INT_NBITS-1:0]  act_int;
  logic [INT_NBITS-1:0]  shd_int;
  logic [INT_NBITS-1:0]  wr_int;
  logic [INT_NBITS-1:0]  sel_int;
  logic [FRAC_NBITS-1:0] acc;
  logic [FRAC_NBITS-1:0] act_frac;
  logic [FRAC_NBITS-1:0] shd_frac;
  logic [FRAC_NBITS-1:0] wr_frac;
  logic [FRAC_NBITS-1:0] sel_frac;
  logic [FRAC_NBITS:0]   sum;
  logic [SCNT_NBITS-1:0] scnt;
  logic                  pend;
  logic                  wr_zero;
  logic                  boundary;

  always_comb begin
    wr_zero  = (i_div[DIV_NBITS-1:FRAC_NBITS] == '0);
    wr_int   = wr_zero ? INT_NBITS'(1) : i_div[DIV_NBITS-1:FRAC_NBITS];
    wr_frac  = i_div[FRAC_NBITS-1:0];
    // Divisor used by whatever reload happens this cycle: a write coinciding
    // with sync takes effect at once, otherwise a pending shadow wins.
    if (i_sync && i_div_wr) begin
      sel_int  = wr_int;
      sel_frac = wr_frac;
    end else if (pend) begin
      sel_int  = shd_int;
      sel_frac = shd_frac;
    end else begin
      sel_int  = act_int;
      sel_frac = act_frac;
    end
    boundary = i_en && !i_sync && (cnt == '0);
    sum      = {1'b0, acc} + {1'b0, sel_frac};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt        <= RST_INT - INT_NBITS'(1);
      acc        <= '0;
      scnt       <= '0;
      act_int    <= RST_INT;
      act_frac   <= RST_FRAC;
      shd_int    <= RST_INT;
      shd_frac   <= RST_FRAC;
      pend       <= 1'b0;
      o_tick     <= 1'b0;
      o_bit_tick <= 1'b0;
      o_div_err  <= 1'b0;
    end else begin
      o_tick     <= boundary;
      o_bit_tick <= boundary && (scnt == SCNT_NBITS'(OVERSAMPLE - 1));
      o_div_err  <= i_div_wr && wr_zero;
      if (i_div_wr) begin
        shd_int  <= wr_int;
        shd_frac <= wr_frac;
      end
      if (i_sync) begin
        cnt      <= sel_int - INT_NBITS'(1);
        acc      <= '0;
        scnt     <= '0;
        act_int  <= sel_int;
        act_frac <= sel_frac;
        pend     <= 1'b0;
      end else begin
        if (boundary) begin
          // The fraction carry stretches the next period by one clock.
          cnt      <= sel_int - INT_NBITS'(1) + INT_NBITS'(sum[FRAC_NBITS]);
          acc      <= sum[FRAC_NBITS-1:0];
          scnt     <= scnt + SCNT_NBITS'(1);
          act_int  <= sel_int;
          act_frac <= sel_frac;
        end else if (i_en) begin
          cnt <= cnt - INT_NBITS'(1);
        end
        // A write on the boundary cycle stays pending for the following one.
        if (i_div_wr) begin
          pend <= 1'b1;
        end else if (boundary) begin
          pend <= 1'b0;
        end
      end
    end
  end

  assign o_div_pend = pend;

endmodule

// File: tb/tb_baudrate_gen_frac.sv
// Testbench for baudrate_gen_frac: directed scenarios with fixed expected
// gaps, plus a randomized run compared against a period-based reference model.
module tb_baudrate_gen_frac;

  localparam int     OS     = 16;
  localparam int     FB     = 4;
  localparam int     IB     = 16;
  localparam longint CLK_HZ = 100000000;
  localparam longint BAUD   = 9600;
  localparam int     DIV_RST = int'((CLK_HZ * (1 << FB) + (OS * BAUD) / 2) / (OS * BAUD));
  localparam int     RST_I   = DIV_RST >> FB;
  localparam int     RST_F   = DIV_RST % (1 << FB);

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          en     = 1'b0;
  logic          sync   = 1'b0;
  logic          div_wr = 1'b0;
  logic [IB+FB-1:0] div = '0;
  logic          tick;
  logic          bit_tick;
  logic          div_err;
  logic          div_pend;

  int vectors    = 0;
  int miscompares = 0;

  baudrate_gen_frac #(
    .CLK_FREQ  (100E6),
    .BAUD_RATE (9600.0),
    .OVERSAMPLE(OS),
    .INT_NBITS (IB),
    .FRAC_NBITS(FB)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_en      (en),
    .i_sync    (sync),
    .i_div_wr  (div_wr),
    .i_div     (div),
    .o_tick    (tick),
    .o_bit_tick(bit_tick),
    .o_div_err (div_err),
    .o_div_pend(div_pend)
  );

  always #5 clk = ~clk;

  // Reference model: counts enabled cycles up to the length of the current
  // period; on reaching it a tick is due and the next period length is
  // I plus the carry out of the running fraction sum.
  int   m_i = RST_I, m_f = RST_F, s_i = RST_I, s_f = RST_F;
  int   m_acc = 0, m_elapsed = 0, m_period = RST_I, m_ticks = 0;
  int   w_i, w_f;
  bit   m_pend = 1'b0;
  logic exp_tick = 1'b0, exp_bit = 1'b0, exp_err = 1'b0, exp_pend = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_i = RST_I; m_f = RST_F; s_i = RST_I; s_f = RST_F;
      m_pend = 1'b0; m_acc = 0; m_elapsed = 0; m_period = RST_I; m_ticks = 0;
      exp_tick = 1'b0; exp_bit = 1'b0; exp_err = 1'b0; exp_pend = 1'b0;
    end else begin
      w_i = int'(div[IB+FB-1:FB]);
      w_f = int'(div[FB-1:0]);
      exp_tick = 1'b0;
      exp_bit  = 1'b0;
      exp_err  = div_wr && (w_i == 0);
      if (w_i == 0) w_i = 1;
      if (sync) begin
        if (div_wr) begin
          m_i = w_i; m_f = w_f;
        end else if (m_pend) begin
          m_i = s_i; m_f = s_f;
        end
        m_pend = 1'b0; m_acc = 0; m_elapsed = 0; m_period = m_i; m_ticks = 0;
      end else begin
        if (en) begin
          m_elapsed++;
          if (m_elapsed == m_period) begin
            exp_tick = 1'b1;
            exp_bit  = ((m_ticks % OS) == OS - 1);
            m_ticks++;
            if (m_pend) begin
              m_i = s_i; m_f = s_f; m_pend = 1'b0;
            end
            m_period  = m_i + (m_acc + m_f) / (1 << FB);
            m_acc     = (m_acc + m_f) % (1 << FB);
            m_elapsed = 0;
          end
        end
        if (div_wr) m_pend = 1'b1;
      end
      if (div_wr) begin
        s_i = w_i; s_f = w_f;
      end
      exp_pend = m_pend;
    end
  end

  // Waits for the next o_tick, sampled on the falling edge; cycles is the
  // number of falling edges taken (limit+1 if the bound expired).
  task automatic wait_tick(input int limit, output int cycles, output logic saw_bit);
    cycles  = 0;
    saw_bit = 1'b0;
    do begin
      @(negedge clk);
      cycles++;
    end while (tick !== 1'b1 && cycles <= limit);
    saw_bit = bit_tick;
  endtask

  task automatic test_reset;
    int c;
    logic b;
    rst_n = 1'b0; en = 1'b1; sync = 1'b0; div_wr = 1'b0; div = '0;
    repeat (3) @(negedge clk);
    vectors++; if (tick !== 1'b0) begin miscompares++; $display("FAIL reset_tick: got %b want 0", tick); end
    vectors++; if (bit_tick !== 1'b0) begin miscompares++; $display("FAIL reset_bit: got %b want 0", bit_tick); end
    vectors++; if (div_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", div_err); end
    vectors++; if (div_pend !== 1'b0) begin miscompares++; $display("FAIL reset_pend: got %b want 0", div_pend); end
    rst_n = 1'b1;
    wait_tick(700, c, b);
    vectors++; if (c !== 651) begin miscompares++; $display("FAIL first_tick: got %0d cycles want 651", c); end
    vectors++; if (b !== 1'b0) begin miscompares++; $display("FAIL first_bit: got %b want 0", b); end
  endtask

  task automatic test_default_gaps;
    int c, sum, n651, n652, bit_at;
    logic b;
    sum = 0; n651 = 0; n652 = 0; bit_at = 0;
    for (int k = 2; k <= 17; k++) begin
      wait_tick(700, c, b);
      sum += c;
      if (c == 651) n651++;
      else if (c == 652) n652++;
      if (b && bit_at == 0) bit_at = k;
    end
    vectors++; if (n651 !== 15) begin miscompares++; $display("FAIL gaps_651: got %0d want 15", n651); end
    vectors++; if (n652 !== 1) begin miscompares++; $display("FAIL gaps_652: got %0d want 1", n652); end
    vectors++; if (sum !== 10417) begin miscompares++; $display("FAIL gaps_span: got %0d want 10417", sum); end
    vectors++; if (bit_at !== 16) begin miscompares++; $display("FAIL bit_tick_pos: got %0d want 16", bit_at); end
  endtask

  task automatic test_div_write;
    int c;
    logic b;
    repeat (99) @(negedge clk);
    div_wr = 1'b1; div = {16'd10, 4'd8};
    @(negedge clk);
    div_wr = 1'b0;
    vectors++; if (div_pend !== 1'b1) begin miscompares++; $display("FAIL pend_set: got %b want 1", div_pend); end
    wait_tick(700, c, b);
    vectors++; if (100 + c !== 651) begin miscompares++; $display("FAIL old_period: got %0d want 651", 100 + c); end
    vectors++; if (div_pend !== 1'b0) begin miscompares++; $display("FAIL pend_clear: got %b want 0", div_pend); end
    for (int k = 0; k < 4; k++) begin
      wait_tick(30, c, b);
      vectors++;
      if (c !== ((k % 2 == 0) ? 10 : 11)) begin
        miscompares++; $display("FAIL frac_gap%0d: got %0d want %0d", k, c, (k % 2 == 0) ? 10 : 11);
      end
    end
  endtask

  task automatic test_enable_pause;
    int c, n;
    logic b;
    n = 0;
    repeat (3) @(negedge clk);
    en = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (tick === 1'b1) n++;
    end
    en = 1'b1;
    wait_tick(200, c, b);
    vectors++; if (n !== 0) begin miscompares++; $display("FAIL pause_ticks: got %0d want 0", n); end
    vectors++; if (103 + c !== 110) begin miscompares++; $display("FAIL pause_gap: got %0d want 110", 103 + c); end
  endtask

  task automatic test_sync;
    int c, bit_at;
    logic b;
    bit_at = 0;
    repeat (7) @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    vectors++; if (tick !== 1'b0) begin miscompares++; $display("FAIL sync_no_tick: got %b want 0", tick); end
    wait_tick(50, c, b);
    vectors++; if (c !== 10) begin miscompares++; $display("FAIL sync_gap: got %0d want 10", c); end
    vectors++; if (b !== 1'b0) begin miscompares++; $display("FAIL sync_first_bit: got %b want 0", b); end
    for (int k = 2; k <= 16; k++) begin
      wait_tick(50, c, b);
      if (b && bit_at == 0) bit_at = k;
    end
    vectors++; if (bit_at !== 16) begin miscompares++; $display("FAIL sync_bit_pos: got %0d want 16", bit_at); end
  endtask

  task automatic test_div_zero;
    div_wr = 1'b1; sync = 1'b1; div = '0;
    @(negedge clk);
    div_wr = 1'b0; sync = 1'b0;
    vectors++; if (div_err !== 1'b1) begin miscompares++; $display("FAIL err_pulse: got %b want 1", div_err); end
    vectors++; if (tick !== 1'b0) begin miscompares++; $display("FAIL zero_sync_tick: got %b want 0", tick); end
    vectors++; if (div_pend !== 1'b0) begin miscompares++; $display("FAIL zero_pend: got %b want 0", div_pend); end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) begin
        vectors++; if (div_err !== 1'b0) begin miscompares++; $display("FAIL err_once: got %b want 0", div_err); end
      end
      vectors++; if (tick !== 1'b1) begin miscompares++; $display("FAIL every_cycle%0d: got %b want 1", i, tick); end
      vectors++; if (bit_tick !== (i == 15)) begin miscompares++; $display("FAIL every_bit%0d: got %b want %b", i, bit_tick, i == 15); end
    end
  endtask

  task automatic test_reset_mid;
    int c;
    logic b;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (tick !== 1'b0) begin miscompares++; $display("FAIL async_tick: got %b want 0", tick); end
    vectors++; if (bit_tick !== 1'b0 || div_err !== 1'b0 || div_pend !== 1'b0) begin
      miscompares++; $display("FAIL async_outs: got %b%b%b want 000", bit_tick, div_err, div_pend);
    end
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    wait_tick(700, c, b);
    vectors++; if (c !== 651) begin miscompares++; $display("FAIL rerelease_tick: got %0d want 651", c); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      vectors++; if (tick !== exp_tick) begin miscompares++; $display("FAIL rnd_tick@%0d: got %b want %b", n, tick, exp_tick); end
      vectors++; if (bit_tick !== exp_bit) begin miscompares++; $display("FAIL rnd_bit@%0d: got %b want %b", n, bit_tick, exp_bit); end
      vectors++; if (div_err !== exp_err) begin miscompares++; $display("FAIL rnd_err@%0d: got %b want %b", n, div_err, exp_err); end
      vectors++; if (div_pend !== exp_pend) begin miscompares++; $display("FAIL rnd_pend@%0d: got %b want %b", n, div_pend, exp_pend); end
      en     = ($urandom % 8) != 0;
      sync   = ($urandom % 64) == 0;
      div_wr = ($urandom % 32) == 0;
      div    = {16'($urandom_range(0, 6)), 4'($urandom % 16)};
    end
    en = 1'b1; sync = 1'b0; div_wr = 1'b0;
  endtask

  initial begin
    test_reset;
    test_default_gaps;
    test_div_write;
    test_enable_pause;
    test_sync;
    test_div_zero;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
